// File: rtl/cpu_mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory stage and the data memory.
//   master (memory stage): drives dmem_req, dmem_we, dmem_addr, dmem_wdata; samples dmem_ack, dmem_rdata
//   slave  (data memory) : samples the request fields; drives dmem_ack, dmem_rdata
interface cpu_mem_stage_if #(
    parameter int unsigned REG_WIDTH = 32
);
    logic                 dmem_req;
    logic                 dmem_we;
    logic [REG_WIDTH-1:0] dmem_addr;
    logic [REG_WIDTH-1:0] dmem_wdata;
    logic                 dmem_ack;
    logic [REG_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ack,
        output dmem_rdata
    );
endinterface

// File: rtl/cpu_mem_stage.sv
// Memory/commit stage: resolves branches, runs data-memory accesses over the
// dmem req/ack bus, stalls upstream while an access is outstanding and emits a
// registered one-cycle writeback bundle per accepted op.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid / in_ready   commit bundle handshake (in_ready is combinational)
//   in_*                  commit bundle fields from EX
//   branch_taken/_target  one-cycle PC redirect pulse and its target
//   dmem                  data-memory bus (master side)
//   wb_*                  registered writeback bundle for WB
module cpu_mem_stage #(
    parameter int unsigned REG_WIDTH = 32,
    parameter int unsigned NUM_REGS  = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_branch,
    input  logic                        in_mem_write,
    input  logic                        in_mem_read,
    input  logic                        in_mem_to_reg,
    input  logic                        in_reg_write,
    input  logic [REG_WIDTH-1:0]        in_alu_result,
    input  logic [REG_WIDTH-1:0]        in_rb_data,
    input  logic [$clog2(NUM_REGS)-1:0] in_reg_dest,
    input  logic [REG_WIDTH-1:0]        in_branch_result,
    input  logic                        in_zero,
    output logic                        branch_taken,
    output logic [REG_WIDTH-1:0]        branch_target,
    cpu_mem_stage_if.master             dmem,
    output logic                        wb_valid,
    output logic                        wb_reg_write,
    output logic                        wb_mem_to_reg,
    output logic [REG_WIDTH-1:0]        wb_alu_result,
    output logic [REG_WIDTH-1:0]        wb_mem_data,
    output logic [$clog2(NUM_REGS)-1:0] wb_reg_dest
);
    localparam int unsigned DEST_W = $clog2(NUM_REGS);

    typedef enum logic {
        IDLE     = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t state_q, state_d;

    // Registered outputs (_q) and their next values (_d)
    logic                 branch_taken_q,  branch_taken_d;
    logic [REG_WIDTH-1:0] branch_target_q, branch_target_d;
    logic                 dmem_req_q,      dmem_req_d;
    logic                 dmem_we_q,       dmem_we_d;
    logic [REG_WIDTH-1:0] dmem_addr_q,     dmem_addr_d;
    logic [REG_WIDTH-1:0] dmem_wdata_q,    dmem_wdata_d;
    logic                 wb_valid_q,      wb_valid_d;
    logic                 wb_reg_write_q,  wb_reg_write_d;
    logic                 wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [REG_WIDTH-1:0] wb_alu_result_q, wb_alu_result_d;
    logic [REG_WIDTH-1:0] wb_mem_data_q,   wb_mem_data_d;
    logic [DEST_W-1:0]    wb_reg_dest_q,   wb_reg_dest_d;

    // Writeback controls parked while the memory access is outstanding;
    // the address doubles as the alu_result to write back.
    logic                 pend_reg_write_q,  pend_reg_write_d;
    logic                 pend_mem_to_reg_q, pend_mem_to_reg_d;
    logic [DEST_W-1:0]    pend_reg_dest_q,   pend_reg_dest_d;

    logic accept;
    logic is_mem;
    logic mem_done;

    assign in_ready = (state_q == IDLE);
    assign accept   = in_valid & in_ready;
    assign is_mem   = in_mem_read | in_mem_write;
    // In MEM_WAIT the request is always up, so a stray ack in IDLE is ignored
    assign mem_done = (state_q == MEM_WAIT) & dmem.dmem_ack;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (accept && is_mem) state_d = MEM_WAIT;
            MEM_WAIT: if (dmem.dmem_ack)    state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Output next-value logic
    always_comb begin
        branch_taken_d    = 1'b0;
        branch_target_d   = branch_target_q;
        dmem_req_d        = dmem_req_q;
        dmem_we_d         = dmem_we_q;
        dmem_addr_d       = dmem_addr_q;
        dmem_wdata_d      = dmem_wdata_q;
        wb_valid_d        = 1'b0;
        wb_reg_write_d    = wb_reg_write_q;
        wb_mem_to_reg_d   = wb_mem_to_reg_q;
        wb_alu_result_d   = wb_alu_result_q;
        wb_mem_data_d     = wb_mem_data_q;
        wb_reg_dest_d     = wb_reg_dest_q;
        pend_reg_write_d  = pend_reg_write_q;
        pend_mem_to_reg_d = pend_mem_to_reg_q;
        pend_reg_dest_d   = pend_reg_dest_q;

        if (accept) begin
            if (in_branch && in_zero) begin
                branch_taken_d  = 1'b1;
                branch_target_d = in_branch_result;
            end
            if (is_mem) begin
                // mem_write wins when both read and write are set
                dmem_req_d        = 1'b1;
                dmem_we_d         = in_mem_write;
                dmem_addr_d       = in_alu_result;
                dmem_wdata_d      = in_rb_data;
                pend_reg_write_d  = in_reg_write;
                pend_mem_to_reg_d = in_mem_to_reg;
                pend_reg_dest_d   = in_reg_dest;
            end else begin
                wb_valid_d      = 1'b1;
                wb_reg_write_d  = in_reg_write;
                wb_mem_to_reg_d = in_mem_to_reg;
                wb_alu_result_d = in_alu_result;
                wb_mem_data_d   = '0;
                wb_reg_dest_d   = in_reg_dest;
            end
        end

        if (mem_done) begin
            dmem_req_d      = 1'b0;
            wb_valid_d      = 1'b1;
            wb_reg_write_d  = pend_reg_write_q;
            wb_mem_to_reg_d = pend_mem_to_reg_q;
            wb_alu_result_d = dmem_addr_q;
            wb_mem_data_d   = dmem_we_q ? '0 : dmem.dmem_rdata;
            wb_reg_dest_d   = pend_reg_dest_q;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_taken_q    <= 1'b0;
            branch_target_q   <= '0;
            dmem_req_q        <= 1'b0;
            dmem_we_q         <= 1'b0;
            dmem_addr_q       <= '0;
            dmem_wdata_q      <= '0;
            wb_valid_q        <= 1'b0;
            wb_reg_write_q    <= 1'b0;
            wb_mem_to_reg_q   <= 1'b0;
            wb_alu_result_q   <= '0;
            wb_mem_data_q     <= '0;
            wb_reg_dest_q     <= '0;
            pend_reg_write_q  <= 1'b0;
            pend_mem_to_reg_q <= 1'b0;
            pend_reg_dest_q   <= '0;
        end else begin
            branch_taken_q    <= branch_taken_d;
            branch_target_q   <= branch_target_d;
            dmem_req_q        <= dmem_req_d;
            dmem_we_q         <= dmem_we_d;
            dmem_addr_q       <= dmem_addr_d;
            dmem_wdata_q      <= dmem_wdata_d;
            wb_valid_q        <= wb_valid_d;
            wb_reg_write_q    <= wb_reg_write_d;
            wb_mem_to_reg_q   <= wb_mem_to_reg_d;
            wb_alu_result_q   <= wb_alu_result_d;
            wb_mem_data_q     <= wb_mem_data_d;
            wb_reg_dest_q     <= wb_reg_dest_d;
            pend_reg_write_q  <= pend_reg_write_d;
            pend_mem_to_reg_q <= pend_mem_to_reg_d;
            pend_reg_dest_q   <= pend_reg_dest_d;
        end
    end

    assign branch_taken    = branch_taken_q;
    assign branch_target   = branch_target_q;
    assign dmem.dmem_req   = dmem_req_q;
    assign dmem.dmem_we    = dmem_we_q;
    assign dmem.dmem_addr  = dmem_addr_q;
    assign dmem.dmem_wdata = dmem_wdata_q;
    assign wb_valid        = wb_valid_q;
    assign wb_reg_write    = wb_reg_write_q;
    assign wb_mem_to_reg   = wb_mem_to_reg_q;
    assign wb_alu_result   = wb_alu_result_q;
    assign wb_mem_data     = wb_mem_data_q;
    assign wb_reg_dest     = wb_reg_dest_q;
endmodule

// File: tb/tb_cpu_mem_stage.sv
// Scoreboard bench for cpu_mem_stage: drivers push expected writeback and
// branch events into queues; negedge monitors pop and compare them.
module tb_cpu_mem_stage;
    localparam int unsigned RW = 32;
    localparam int unsigned DW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready;
    logic          in_branch, in_mem_write, in_mem_read, in_mem_to_reg, in_reg_write;
    logic [RW-1:0] in_alu_result, in_rb_data, in_branch_result;
    logic [DW-1:0] in_reg_dest;
    logic          in_zero;
    logic          branch_taken;
    logic [RW-1:0] branch_target;
    logic          wb_valid, wb_reg_write, wb_mem_to_reg;
    logic [RW-1:0] wb_alu_result, wb_mem_data;
    logic [DW-1:0] wb_reg_dest;

    cpu_mem_stage_if #(.REG_WIDTH(RW)) dmem_if ();

    cpu_mem_stage #(.REG_WIDTH(RW), .NUM_REGS(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_branch(in_branch), .in_mem_write(in_mem_write), .in_mem_read(in_mem_read),
        .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
        .in_alu_result(in_alu_result), .in_rb_data(in_rb_data), .in_reg_dest(in_reg_dest),
        .in_branch_result(in_branch_result), .in_zero(in_zero),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .dmem(dmem_if.master),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_alu_result(wb_alu_result), .wb_mem_data(wb_mem_data), .wb_reg_dest(wb_reg_dest)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          reg_write;
        logic          mem_to_reg;
        logic [RW-1:0] alu_result;
        logic [RW-1:0] mem_data;
        logic [DW-1:0] reg_dest;
    } wb_t;

    wb_t           wb_q[$];
    int unsigned   wb_cyc_q[$];
    logic [RW-1:0] br_q[$];
    int unsigned   br_cyc_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Writeback monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            if (wb_q.size() == 0) begin
                check("wb_spurious", 128'(wb_valid), 128'(0));
            end else begin
                wb_t         e;
                int unsigned ec;
                e  = wb_q.pop_front();
                ec = wb_cyc_q.pop_front();
                check("wb_bundle", 128'({wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_mem_data, wb_reg_dest}),
                      128'(e));
                check("wb_cycle", 128'(cyc), 128'(ec));
            end
        end
    end

    // Branch redirect monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1 && branch_taken === 1'b1) begin
            if (br_q.size() == 0) begin
                check("branch_spurious", 128'(branch_taken), 128'(0));
            end else begin
                logic [RW-1:0] t;
                int unsigned   tc;
                t  = br_q.pop_front();
                tc = br_cyc_q.pop_front();
                check("branch_target", 128'(branch_target), 128'(t));
                check("branch_cycle", 128'(cyc), 128'(tc));
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Issue one op (called #1 after a posedge); memory ops are completed with
    // an ack after wait_n request cycles. ALU ops leave in_valid high.
    task automatic issue(input logic br, input logic mw, input logic mr, input logic m2r,
                         input logic rw, input logic [RW-1:0] alu, input logic [RW-1:0] rb,
                         input logic [DW-1:0] dest, input logic [RW-1:0] tgt, input logic zero,
                         input int wait_n, input logic [RW-1:0] rdata);
        int unsigned acc;
        logic        mem;
        wb_t         e;
        mem = mw | mr;
        check("in_ready_idle", 128'(in_ready), 128'(1));
        in_valid = 1'b1; in_branch = br; in_mem_write = mw; in_mem_read = mr;
        in_mem_to_reg = m2r; in_reg_write = rw; in_alu_result = alu; in_rb_data = rb;
        in_reg_dest = dest; in_branch_result = tgt; in_zero = zero;
        acc = cyc + 1;
        e.reg_write = rw; e.mem_to_reg = m2r; e.alu_result = alu; e.reg_dest = dest;
        e.mem_data = (mr && !mw) ? rdata : '0;
        wb_q.push_back(e);
        wb_cyc_q.push_back(mem ? acc + 1 + wait_n : acc);
        if (br && zero) begin
            br_q.push_back(tgt);
            br_cyc_q.push_back(acc);
        end
        @(posedge clk);
        #1;
        if (mem) begin
            in_valid = 1'b0;
            check("req_up", 128'(dmem_if.dmem_req), 128'(1));
            check("req_fields", 128'({dmem_if.dmem_we, dmem_if.dmem_addr, dmem_if.dmem_wdata}),
                  128'({mw, alu, rb}));
            check("in_ready_busy", 128'(in_ready), 128'(0));
            for (int i = 0; i < wait_n; i++) begin
                @(posedge clk);
                #1;
                check("req_held", 128'({dmem_if.dmem_req, dmem_if.dmem_addr, in_ready}),
                      128'({1'b1, alu, 1'b0}));
            end
            dmem_if.dmem_ack = 1'b1;
            dmem_if.dmem_rdata = rdata;
            @(posedge clk);
            #1;
            dmem_if.dmem_ack = 1'b0;
            dmem_if.dmem_rdata = 32'hBAD0_BAD0;
            check("req_dropped", 128'({dmem_if.dmem_req, in_ready}), 128'({1'b0, 1'b1}));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b1; in_branch = 1'b1; in_mem_write = 1'b0; in_mem_read = 1'b1;
        in_mem_to_reg = 1'b1; in_reg_write = 1'b1; in_alu_result = 32'h55; in_rb_data = 32'h66;
        in_reg_dest = 4'd9; in_branch_result = 32'h77; in_zero = 1'b1;
        dmem_if.dmem_ack = 1'b0; dmem_if.dmem_rdata = '0;

        // Reset held two cycles with in_valid high
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 128'({branch_taken, branch_target, dmem_if.dmem_req, dmem_if.dmem_we,
                                     dmem_if.dmem_addr, dmem_if.dmem_wdata, wb_valid}), 128'(0));
        check("reset_wb_fields", 128'({wb_reg_write, wb_mem_to_reg, wb_alu_result, wb_mem_data,
                                       wb_reg_dest}), 128'(0));
        in_valid = 1'b0;
        rst_n = 1'b1;
        check("reset_in_ready", 128'(in_ready), 128'(1));
        idle(2);

        // ALU op, then three back-to-back ALU ops
        issue(0, 0, 0, 0, 1, 32'h1234, 32'h9999, 4'd3, 32'h0, 0, 0, 32'h0);
        idle(2);
        issue(0, 0, 0, 0, 1, 32'h1, 32'h0, 4'd4, 32'h0, 0, 0, 32'h0);
        issue(0, 0, 0, 1, 0, 32'h2, 32'h0, 4'd5, 32'h0, 1, 0, 32'h0);
        issue(0, 0, 0, 0, 1, 32'h3, 32'h0, 4'd6, 32'h0, 0, 0, 32'h0);
        idle(2);

        // Load with three wait cycles, then zero-wait load
        issue(0, 0, 1, 1, 1, 32'h40, 32'h0, 4'd7, 32'h0, 0, 3, 32'hDEAD_BEEF);
        idle(1);
        issue(0, 0, 1, 1, 1, 32'h44, 32'h0, 4'd8, 32'h0, 0, 0, 32'h1122_3344);
        idle(1);

        // Store with both read and write set: write wins, no load data
        issue(0, 1, 1, 0, 0, 32'h80, 32'hCAFE, 4'd2, 32'h0, 0, 1, 32'hFFFF_FFFF);
        idle(2);

        // Taken branch, then not-taken branch
        issue(1, 0, 0, 0, 0, 32'h0, 32'h0, 4'd0, 32'h200, 1, 0, 32'h0);
        idle(3);
        check("branch_target_hold", 128'({branch_taken, branch_target}), 128'({1'b0, 32'h200}));
        issue(1, 0, 0, 0, 0, 32'h5, 32'h0, 4'd1, 32'h300, 0, 0, 32'h0);
        idle(3);
        check("branch_nt_hold", 128'({branch_taken, branch_target}), 128'({1'b0, 32'h200}));

        // Ack with no request outstanding is ignored
        dmem_if.dmem_ack = 1'b1;
        dmem_if.dmem_rdata = 32'h1357_9BDF;
        idle(1);
        dmem_if.dmem_ack = 1'b0;
        check("stray_ack", 128'({dmem_if.dmem_req, in_ready}), 128'({1'b0, 1'b1}));
        idle(2);

        // Reset during an outstanding load: abandoned, no writeback
        in_valid = 1'b1; in_branch = 1'b0; in_mem_write = 1'b0; in_mem_read = 1'b1;
        in_mem_to_reg = 1'b1; in_reg_write = 1'b1; in_alu_result = 32'h90; in_reg_dest = 4'd10;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("abort_req_up", 128'(dmem_if.dmem_req), 128'(1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_req_dropped", 128'({dmem_if.dmem_req, dmem_if.dmem_addr, in_ready}),
              128'({1'b0, 32'h0, 1'b1}));
        rst_n = 1'b1;
        dmem_if.dmem_ack = 1'b1;
        dmem_if.dmem_rdata = 32'hAAAA_5555;
        idle(1);
        dmem_if.dmem_ack = 1'b0;
        idle(3);
        check("abort_idle", 128'({dmem_if.dmem_req, in_ready, branch_target}), 128'({1'b0, 1'b1, 32'h0}));

        // Normal operation resumes after the abort
        issue(0, 0, 0, 0, 1, 32'hABCD, 32'h0, 4'd15, 32'h0, 0, 0, 32'h0);
        idle(4);

        check("wb_queue_drained", 128'(wb_q.size()), 128'(0));
        check("branch_queue_drained", 128'(br_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
